multi_cycle_cu: RTL
===================

// Module: multi_cycle_cu
// PURPOSE
//  Multi-cycle FSM control unit for the multi-cycle processor datapath. It keeps the existing
//  opcode set and one-hot ALU function encoding, and sequences each instruction through
//  FETCH/DECODE/EXEC/MEMACC/WBACK. Memory accesses use a ready handshake with a timeout.
//  It drives datapath muxes, register-file and memory strobes, and PC/IR write enables.
// PARAMETERS
//  OPC_W        4   opcode width; opcode = low 4 bits, upper bits must be 0 else illegal
//  FUNC_W       8   funcCtrl width (one-hot: ADD=bit1, SUB=bit2, AND=bit3, OR=bit4, NOP=bit6)
//  MEM_TIMEOUT  15  max wait cycles for memReady per access (>=1)
//  CNT_W        8   width of illegalCnt saturating counter
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           asynchronous, active-low reset
//  opcode      in   OPC_W       instruction opcode from IR, sampled in DECODE
//  zero        in   1           ALU zero flag, used in EXEC of BRANCHZ
//  memReady    in   1           memory completes current read/write this cycle
//  state       out  3           current FSM state, for debug
//  irWrite     out  1           load IR
//  pcWrite     out  1           load PC (PC+1, jump or branch target per jumpSel/branchSel)
//  iOrD        out  1           memory address source: 0=PC, 1=data address
//  memRead, memWrite                      out 1  memory strobes
//  selDM, regWrite, regSel, regJsel, selRj out 1  register-file write data, dest and source selects
//  imSel, selALU, selFunc, selCtrl        out 1  ALU operand and function-source selects
//  jumpSel, branchSel                     out 1  PC source selects
//  funcCtrl    out  FUNC_W      ALU function when selCtrl=1, else NOP
//  instrDone   out  1           1-cycle pulse when an instruction retires
//  illegalOp   out  1           1-cycle pulse when an illegal opcode is in DECODE
//  memErr      out  1           1-cycle pulse when a memory access times out
//  illegalCnt  out  CNT_W       saturating count of illegal opcodes
// BEHAVIOUR
//  Reset while rst=0: state=FETCH, opReg=0, wait counter=0, illegalCnt=0. All outputs are
//   forced to 0 (funcCtrl=NOP). Reset mid-access drops all strobes in the same cycle.
//  Opcodes: LOAD 0000, STORE 0001, JUMP 0010, BRANCHZ 0100, TYPEC 1000, ADDI 1100, SUBI 1101,
//   ANDI 1110, ORI 1111. Any other value is illegal.
//  Outputs are decoded from state and opReg. Defaults are 0 and funcCtrl=NOP.
//  FETCH: memRead=1, iOrD=0. On memReady: irWrite=1, pcWrite=1 (PC+1), -> DECODE.
//  DECODE: opReg<=opcode. Transitions:
//   - LOAD/STORE -> MEMACC.
//   - JUMP: jumpSel=1, selRj=1, pcWrite=1, instrDone=1 -> FETCH.
//   - BRANCHZ, TYPEC, immediate ops -> EXEC.
//   - illegal: illegalOp=1, illegalCnt+1 (saturating), -> FETCH, no other strobe.
//  EXEC:
//   - TYPEC: selFunc=1, selALU=1, selRj=1.
//   - ADDI/SUBI/ANDI/ORI: selCtrl=1, imSel=1, selALU=1, funcCtrl=ADD/SUB/AND/OR.
//   - ALU ops then -> WBACK.
//   - BRANCHZ: selCtrl=1, funcCtrl=SUB, branchSel=1, selRj=1, pcWrite=zero,
//     instrDone=1, -> FETCH.
//  MEMACC: iOrD=1, selRj=1. memRead (LOAD) or memWrite (STORE) is held until memReady.
//   - On ready, STORE: instrDone=1, -> FETCH.
//   - On ready, LOAD: -> WBACK. Read data is captured by the datapath on memReady.
//  WBACK: regWrite=1 for one cycle, instrDone=1, -> FETCH. Holds the EXEC selects/funcCtrl.
//   LOAD: selDM=1. TYPEC: regSel=1. Immediate ops: regJsel=1.
//  Timeout: a wait counter runs in FETCH/MEMACC while memReady=0 and clears on state change.
//   - If memReady is still 0 when the counter reaches MEM_TIMEOUT: memErr=1, strobes drop,
//     no pcWrite/irWrite/regWrite, -> FETCH (instruction retried).
//   - memReady in the same cycle as the timeout: memReady wins, no memErr.
//  Latency with memReady=1 every cycle:
//   - JUMP / illegal: 2 cycles.
//   - STORE, BRANCHZ: 3 cycles.
//   - TYPEC, immediate ops, LOAD: 4 cycles.
// STRUCTURE
//  Package multi_cycle_cu_pkg: opcode constants, funcCtrl one-hot constants, 3-bit state
//   encoding (FETCH=0, DECODE=1, EXEC=2, MEMACC=3, WBACK=4), opcode class typedef.
//  Sub-module mc_op_decode: combinational opcode -> {class, aluFunc, illegal}. Used on
//   opcode in DECODE and on opReg in later states.
// TESTING
//  ADDI, memReady=1: states 0,1,2,4. regJsel=1 and regWrite=1 in cycle 4 only. funcCtrl=0x02
//   in EXEC/WBACK, instrDone in cycle 4.
//  LOAD, memReady low 3 cycles in MEMACC: memRead=1, iOrD=1 for 4 cycles. Then WBACK with
//   selDM=1, regWrite=1.
//  BRANCHZ: zero=1 -> pcWrite=1, branchSel=1, funcCtrl=0x04 in EXEC. zero=0 -> pcWrite=0.
//   Both return to FETCH.
//  MEM_TIMEOUT=4, memReady stuck 0 in FETCH: memErr pulses after 4 wait cycles. No irWrite
//   or pcWrite. State returns to FETCH.
//  Opcode 0011: illegalOp pulse, illegalCnt 0->1. No regWrite/memWrite. After 2^CNT_W+1
//   illegal opcodes, illegalCnt holds at max.
//  STORE with rst low mid-MEMACC: memWrite falls the same cycle. After release: FETCH,
//   illegalCnt=0.

Source files
------------

// File: rtl/multi_cycle_cu_pkg.sv
// Shared definitions for the multi-cycle control unit.
//  - Opcode constants (low 4 bits of the IR opcode field).
//  - Bit positions of the one-hot ALU function word (funcCtrl).
//  - 3-bit FSM state encoding, which is also exported on the debug port.
//  - Opcode class and ALU operation enums produced by the opcode decoder.
package multi_cycle_cu_pkg;

  // Opcode values; any other value is illegal.
  localparam logic [3:0] OP_LOAD    = 4'b0000;
  localparam logic [3:0] OP_STORE   = 4'b0001;
  localparam logic [3:0] OP_JUMP    = 4'b0010;
  localparam logic [3:0] OP_BRANCHZ = 4'b0100;
  localparam logic [3:0] OP_TYPEC   = 4'b1000;
  localparam logic [3:0] OP_ADDI    = 4'b1100;
  localparam logic [3:0] OP_SUBI    = 4'b1101;
  localparam logic [3:0] OP_ANDI    = 4'b1110;
  localparam logic [3:0] OP_ORI     = 4'b1111;

  // Bit positions inside the one-hot funcCtrl word.
  localparam int FUNC_ADD_BIT = 1;
  localparam int FUNC_SUB_BIT = 2;
  localparam int FUNC_AND_BIT = 3;
  localparam int FUNC_OR_BIT  = 4;
  localparam int FUNC_NOP_BIT = 6;

  // FSM states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMACC = 3'd3,
    ST_WBACK  = 3'd4
  } state_t;

  // Instruction class, selects the path through the FSM.
  typedef enum logic [2:0] {
    CLS_LOAD    = 3'd0,
    CLS_STORE   = 3'd1,
    CLS_JUMP    = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_TYPEC   = 3'd4,
    CLS_IMM     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  // ALU operation requested by the control unit.
  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4
  } alu_op_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decoder.
//  op       in   OPC_W  opcode (live IR opcode in DECODE, latched opReg afterwards)
//  op_class out         instruction class
//  alu_op   out         ALU operation for immediate instructions, NOP otherwise
//  illegal  out         opcode is not part of the instruction set
// Only the low 4 bits carry the opcode; any set bit above them makes it illegal.
module mc_op_decode
  import multi_cycle_cu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] op,
  output op_class_t        op_class,
  output alu_op_t          alu_op,
  output logic             illegal
);

  logic [3:0] low_s;
  logic       upper_nz_s;

  assign low_s      = op[3:0];
  assign upper_nz_s = |(op >> 3'd4);

  // Classify the opcode and pick the ALU operation for immediate forms.
  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = ALU_NOP;
    case (low_s)
      OP_LOAD:    op_class = CLS_LOAD;
      OP_STORE:   op_class = CLS_STORE;
      OP_JUMP:    op_class = CLS_JUMP;
      OP_BRANCHZ: op_class = CLS_BRANCH;
      OP_TYPEC:   op_class = CLS_TYPEC;
      OP_ADDI: begin
        op_class = CLS_IMM;
        alu_op   = ALU_ADD;
      end
      OP_SUBI: begin
        op_class = CLS_IMM;
        alu_op   = ALU_SUB;
      end
      OP_ANDI: begin
        op_class = CLS_IMM;
        alu_op   = ALU_AND;
      end
      OP_ORI: begin
        op_class = CLS_IMM;
        alu_op   = ALU_OR;
      end
      default: begin
        op_class = CLS_ILLEGAL;
        alu_op   = ALU_NOP;
      end
    endcase
    if (upper_nz_s) begin
      op_class = CLS_ILLEGAL;
      alu_op   = ALU_NOP;
    end else begin
      op_class = op_class;
      alu_op   = alu_op;
    end
  end

  assign illegal = (op_class == CLS_ILLEGAL);

endmodule

// File: rtl/multi_cycle_cu.sv
// Multi-cycle processor control unit.
// Sequences each instruction through FETCH/DECODE/EXEC/MEMACC/WBACK and drives
// the datapath selects, register-file and memory strobes, and PC/IR enables.
// Ports:
//  clk, rst               clock (rising edge), asynchronous active-low reset
//  opcode                 IR opcode, sampled in DECODE
//  zero                   ALU zero flag, used by BRANCHZ in EXEC
//  memReady               memory completes the current access this cycle
//  state                  current FSM state (debug)
//  irWrite, pcWrite       IR / PC load enables
//  iOrD                   memory address source (0=PC, 1=data address)
//  memRead, memWrite      memory strobes
//  selDM..selRj           register-file data/dest/source selects
//  imSel..selCtrl         ALU operand and function-source selects
//  jumpSel, branchSel     PC source selects
//  funcCtrl               one-hot ALU function (NOP unless selCtrl)
//  instrDone              pulse when an instruction retires
//  illegalOp              pulse when an illegal opcode is decoded
//  memErr                 pulse when a memory access times out
//  illegalCnt             saturating count of illegal opcodes
// Outputs are Mealy-decoded from state, opReg and memReady so a memory
// handshake completes in the same cycle memReady is seen. While rst is low
// every output is forced inactive, so strobes drop as soon as reset asserts.
module multi_cycle_cu
  import multi_cycle_cu_pkg::*;
#(
  parameter int OPC_W       = 4,
  parameter int FUNC_W      = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              zero,
  input  logic              memReady,
  output logic [2:0]        state,
  output logic              irWrite,
  output logic              pcWrite,
  output logic              iOrD,
  output logic              memRead,
  output logic              memWrite,
  output logic              selDM,
  output logic              regWrite,
  output logic              regSel,
  output logic              regJsel,
  output logic              selRj,
  output logic              imSel,
  output logic              selALU,
  output logic              selFunc,
  output logic              selCtrl,
  output logic              jumpSel,
  output logic              branchSel,
  output logic [FUNC_W-1:0] funcCtrl,
  output logic              instrDone,
  output logic              illegalOp,
  output logic              memErr,
  output logic [CNT_W-1:0]  illegalCnt
);

  localparam int                TO_W         = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_MAX       = TO_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [FUNC_W-1:0] FUNC_NOP_VEC = FUNC_W'(1'b1) << FUNC_NOP_BIT;

  // Map an ALU operation onto the one-hot funcCtrl word.
  function automatic logic [FUNC_W-1:0] func_onehot(input alu_op_t a);
    logic [FUNC_W-1:0] v;
    v = {FUNC_W{1'b0}};
    case (a)
      ALU_ADD: v[FUNC_ADD_BIT] = 1'b1;
      ALU_SUB: v[FUNC_SUB_BIT] = 1'b1;
      ALU_AND: v[FUNC_AND_BIT] = 1'b1;
      ALU_OR:  v[FUNC_OR_BIT]  = 1'b1;
      default: v[FUNC_NOP_BIT] = 1'b1;
    endcase
    return v;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [OPC_W-1:0] op_r;
  logic [TO_W-1:0]  wait_cnt_r;
  logic [TO_W-1:0]  wait_cnt_nxt_s;
  logic [CNT_W-1:0] ill_cnt_r;

  logic [OPC_W-1:0] dec_in_s;
  op_class_t        dec_class_s;
  alu_op_t          dec_alu_s;
  logic             dec_illegal_s;
  logic             timeout_s;
  logic             is_store_s;

  logic    ir_write_s, pc_write_s, iord_s, mem_read_s, mem_write_s;
  logic    sel_dm_s, reg_write_s, reg_sel_s, reg_jsel_s, sel_rj_s;
  logic    im_sel_s, sel_alu_s, sel_func_s, sel_ctrl_s;
  logic    jump_sel_s, branch_sel_s, instr_done_s, illegal_op_s, mem_err_s;
  alu_op_t alu_sel_s;

  // The live opcode is only meaningful in DECODE; later states use opReg.
  assign dec_in_s = (state_r == ST_DECODE) ? opcode : op_r;

  mc_op_decode #(
    .OPC_W (OPC_W)
  ) u_dec (
    .op       (dec_in_s),
    .op_class (dec_class_s),
    .alu_op   (dec_alu_s),
    .illegal  (dec_illegal_s)
  );

  // A ready in the timeout cycle wins, so the timeout needs memReady low.
  assign timeout_s  = (wait_cnt_r == TO_MAX) && !memReady;
  assign is_store_s = (dec_class_s == CLS_STORE);

  // Next-state and Mealy output decode.
  always_comb begin
    state_nxt_s  = state_r;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    sel_dm_s     = 1'b0;
    reg_write_s  = 1'b0;
    reg_sel_s    = 1'b0;
    reg_jsel_s   = 1'b0;
    sel_rj_s     = 1'b0;
    im_sel_s     = 1'b0;
    sel_alu_s    = 1'b0;
    sel_func_s   = 1'b0;
    sel_ctrl_s   = 1'b0;
    jump_sel_s   = 1'b0;
    branch_sel_s = 1'b0;
    instr_done_s = 1'b0;
    illegal_op_s = 1'b0;
    mem_err_s    = 1'b0;
    alu_sel_s    = ALU_NOP;
    case (state_r)
      ST_FETCH: begin
        if (memReady) begin
          mem_read_s  = 1'b1;
          ir_write_s  = 1'b1;
          pc_write_s  = 1'b1;
          state_nxt_s = ST_DECODE;
        end else if (timeout_s) begin
          // Drop the read and retry the fetch from scratch.
          mem_err_s   = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          mem_read_s  = 1'b1;
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec_illegal_s) begin
          illegal_op_s = 1'b1;
          state_nxt_s  = ST_FETCH;
        end else begin
          case (dec_class_s)
            CLS_LOAD, CLS_STORE: state_nxt_s = ST_MEMACC;
            CLS_JUMP: begin
              jump_sel_s   = 1'b1;
              sel_rj_s     = 1'b1;
              pc_write_s   = 1'b1;
              instr_done_s = 1'b1;
              state_nxt_s  = ST_FETCH;
            end
            CLS_BRANCH, CLS_TYPEC, CLS_IMM: state_nxt_s = ST_EXEC;
            default: state_nxt_s = ST_FETCH;
          endcase
        end
      end
      ST_EXEC: begin
        case (dec_class_s)
          CLS_TYPEC: begin
            sel_func_s  = 1'b1;
            sel_alu_s   = 1'b1;
            sel_rj_s    = 1'b1;
            state_nxt_s = ST_WBACK;
          end
          CLS_IMM: begin
            sel_ctrl_s  = 1'b1;
            im_sel_s    = 1'b1;
            sel_alu_s   = 1'b1;
            alu_sel_s   = dec_alu_s;
            state_nxt_s = ST_WBACK;
          end
          CLS_BRANCH: begin
            // Compare by subtraction; take the branch only on zero.
            sel_ctrl_s   = 1'b1;
            alu_sel_s    = ALU_SUB;
            branch_sel_s = 1'b1;
            sel_rj_s     = 1'b1;
            pc_write_s   = zero;
            instr_done_s = 1'b1;
            state_nxt_s  = ST_FETCH;
          end
          default: state_nxt_s = ST_FETCH;
        endcase
      end
      ST_MEMACC: begin
        iord_s   = 1'b1;
        sel_rj_s = 1'b1;
        if (memReady) begin
          if (is_store_s) begin
            mem_write_s  = 1'b1;
            instr_done_s = 1'b1;
            state_nxt_s  = ST_FETCH;
          end else begin
            mem_read_s  = 1'b1;
            state_nxt_s = ST_WBACK;
          end
        end else if (timeout_s) begin
          mem_err_s   = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          if (is_store_s) begin
            mem_write_s = 1'b1;
          end else begin
            mem_read_s = 1'b1;
          end
          state_nxt_s = ST_MEMACC;
        end
      end
      ST_WBACK: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_nxt_s  = ST_FETCH;
        // Keep the EXEC selects stable so the ALU result is still valid.
        case (dec_class_s)
          CLS_LOAD: sel_dm_s = 1'b1;
          CLS_TYPEC: begin
            sel_func_s = 1'b1;
            sel_alu_s  = 1'b1;
            sel_rj_s   = 1'b1;
            reg_sel_s  = 1'b1;
          end
          CLS_IMM: begin
            sel_ctrl_s = 1'b1;
            im_sel_s   = 1'b1;
            sel_alu_s  = 1'b1;
            alu_sel_s  = dec_alu_s;
            reg_jsel_s = 1'b1;
          end
          default: begin
            reg_write_s  = 1'b0;
            instr_done_s = 1'b0;
          end
        endcase
      end
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // Wait counter: counts memReady-low cycles in FETCH/MEMACC, cleared on
  // any state change and after a timeout so each retry gets a full budget.
  always_comb begin
    if ((state_nxt_s != state_r) || mem_err_s) begin
      wait_cnt_nxt_s = {TO_W{1'b0}};
    end else if (!memReady && ((state_r == ST_FETCH) || (state_r == ST_MEMACC))) begin
      wait_cnt_nxt_s = wait_cnt_r + TO_W'(1'b1);
    end else begin
      wait_cnt_nxt_s = {TO_W{1'b0}};
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_FETCH;
      wait_cnt_r <= {TO_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Opcode latch, loaded while the instruction is in DECODE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r <= {OPC_W{1'b0}};
    end else if (state_r == ST_DECODE) begin
      op_r <= opcode;
    end else begin
      op_r <= op_r;
    end
  end

  // Saturating illegal-opcode counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ill_cnt_r <= {CNT_W{1'b0}};
    end else if (illegal_op_s && (ill_cnt_r != CNT_MAX)) begin
      ill_cnt_r <= ill_cnt_r + CNT_W'(1'b1);
    end else begin
      ill_cnt_r <= ill_cnt_r;
    end
  end

  assign state      = rst ? state_r : ST_FETCH;
  assign irWrite    = rst & ir_write_s;
  assign pcWrite    = rst & pc_write_s;
  assign iOrD       = rst & iord_s;
  assign memRead    = rst & mem_read_s;
  assign memWrite   = rst & mem_write_s;
  assign selDM      = rst & sel_dm_s;
  assign regWrite   = rst & reg_write_s;
  assign regSel     = rst & reg_sel_s;
  assign regJsel    = rst & reg_jsel_s;
  assign selRj      = rst & sel_rj_s;
  assign imSel      = rst & im_sel_s;
  assign selALU     = rst & sel_alu_s;
  assign selFunc    = rst & sel_func_s;
  assign selCtrl    = rst & sel_ctrl_s;
  assign jumpSel    = rst & jump_sel_s;
  assign branchSel  = rst & branch_sel_s;
  assign instrDone  = rst & instr_done_s;
  assign illegalOp  = rst & illegal_op_s;
  assign memErr     = rst & mem_err_s;
  assign funcCtrl   = rst ? func_onehot(alu_sel_s) : FUNC_NOP_VEC;
  assign illegalCnt = ill_cnt_r;

endmodule
